// File: rtl/thumb_ifetch_port.sv
// thumb_ifetch_port
//
// Memory-side responder for the Thumb instruction fetch path. It serves
// 16-bit instructions to the IF stage from a one-word buffer (E0). On a
// miss it issues a 32-bit word read over a request/acknowledge port, then
// fills E0. One word read therefore covers two sequential halfword fetches.
// A branch redirect (FLUSH) invalidates buffered data and drops any read
// that is still in flight.
//
// Optional feature macro: IFETCH_PREFETCH_EN
//   When defined, a second entry (E1) holds the next sequential word. The
//   block prefetches it while idle. A hit on E1 promotes it to E0.
//   When undefined, only E0 exists and there is no prefetch logic.
//
// Ports:
//   CLK         in   system clock, rising edge
//   nRST        in   asynchronous active-low reset
//   FETCH_REQ   in   IF stage fetch request
//   FETCH_ADDR  in   halfword fetch address (bit 0 ignored)
//   FLUSH       in   branch redirect, discard buffered and in-flight data
//   FETCH_RDY   out  INST is valid for FETCH_ADDR this cycle (combinational)
//   INST        out  fetched halfword, zero when FETCH_RDY is low
//   MEM_REQ     out  word read request (registered)
//   MEM_ADDR    out  word-aligned read address (registered)
//   MEM_ACK     in   read complete, MEM_RDATA valid
//   MEM_RDATA   in   read data, little-endian

module thumb_ifetch_port (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        FETCH_REQ,
   input  logic [31:0] FETCH_ADDR,
   input  logic        FLUSH,
   output logic        FETCH_RDY,
   output logic [15:0] INST,
   output logic        MEM_REQ,
   output logic [31:0] MEM_ADDR,
   input  logic        MEM_ACK,
   input  logic [31:0] MEM_RDATA
);

`ifdef IFETCH_PREFETCH_EN
   typedef enum logic [1:0] {StIdle, StWait, StDrop, StPfWait} state_e;
`else
   typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;
`endif

   state_e state_q, state_d;

   // Entry E0
   logic        valid0_q, valid0_d;
   logic [29:0] tag0_q, tag0_d;
   logic [31:0] data0_q, data0_d;

   // Memory request registers; the address is held as a word tag
   logic        mem_req_q, mem_req_d;
   logic [29:0] mem_tag_q, mem_tag_d;

   logic [29:0] fetch_tag;
   logic        lookup;
   logic        hit0;
   logic        hit;
   logic        demand_miss;
   logic        fill0;
   logic [31:0] hit_word;

   // Halfword selection only uses FETCH_ADDR[1]
   logic unused_addr_bit;
   assign unused_addr_bit = FETCH_ADDR[0];

   assign fetch_tag = FETCH_ADDR[31:2];
   // FLUSH suppresses every lookup in its cycle
   assign lookup    = FETCH_REQ & ~FLUSH;
   assign hit0      = lookup & valid0_q & (tag0_q == fetch_tag);

`ifdef IFETCH_PREFETCH_EN
   // Entry E1 (next sequential word)
   logic        valid1_q, valid1_d;
   logic [29:0] tag1_q, tag1_d;
   logic [31:0] data1_q, data1_d;

   logic        hit1;
   logic        promote;
   logic        fill1;
   logic        base_valid;
   logic [29:0] base_tag;
   logic [29:0] pf_tag;
   logic        e1_ready;
   logic        pf_go;

   assign hit1    = lookup & valid1_q & (tag1_q == fetch_tag);
   assign promote = hit1 & ~hit0;

   // Prefetch targets the word after whatever E0 will hold at the next edge,
   // so a promotion this cycle already launches the following prefetch.
   assign base_valid = valid0_q | promote;
   assign base_tag   = promote ? tag1_q : tag0_q;
   assign pf_tag     = base_tag + 30'd1;
   assign e1_ready   = valid1_q & ~promote & (tag1_q == pf_tag);
   assign pf_go      = ~FLUSH & base_valid & ~e1_ready;

   assign hit = hit0 | hit1;
`else
   assign hit = hit0;
`endif

   assign demand_miss = lookup & ~hit;

   // Read data mux; zero whenever nothing hits so INST reads 0
   always_comb begin
      hit_word = 32'h0000_0000;
      if (hit0) begin
         hit_word = data0_q;
`ifdef IFETCH_PREFETCH_EN
      end else if (hit1) begin
         hit_word = data1_q;
`endif
      end
   end

   assign FETCH_RDY = hit;
   assign INST      = FETCH_ADDR[1] ? hit_word[31:16] : hit_word[15:0];
   assign MEM_REQ   = mem_req_q;
   assign MEM_ADDR  = {mem_tag_q, 2'b00};

   // ---------------------------------------------------------------------
   // FSM: next state and memory request
   // ---------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      mem_req_d = mem_req_q;
      mem_tag_d = mem_tag_q;
      fill0     = 1'b0;
`ifdef IFETCH_PREFETCH_EN
      fill1     = 1'b0;
`endif

      case (state_q)
         StIdle: begin
            if (demand_miss) begin
               mem_req_d = 1'b1;
               mem_tag_d = fetch_tag;
               state_d   = StWait;
`ifdef IFETCH_PREFETCH_EN
            end else if (pf_go) begin
               mem_req_d = 1'b1;
               mem_tag_d = pf_tag;
               state_d   = StPfWait;
`endif
            end
         end

         StWait: begin
            if (MEM_ACK) begin
               // Data arriving together with FLUSH belongs to the old path
               mem_req_d = 1'b0;
               fill0     = ~FLUSH;
               state_d   = StIdle;
            end else if (FLUSH) begin
               state_d = StDrop;
            end
         end

         // A request is never retracted: wait out the ACK and discard it
         StDrop: begin
            if (MEM_ACK) begin
               mem_req_d = 1'b0;
               state_d   = StIdle;
            end
         end

`ifdef IFETCH_PREFETCH_EN
         // A demand miss here waits; it is re-evaluated back in StIdle
         StPfWait: begin
            if (MEM_ACK) begin
               mem_req_d = 1'b0;
               fill1     = ~FLUSH;
               state_d   = StIdle;
            end else if (FLUSH) begin
               state_d = StDrop;
            end
         end
`endif

         default: begin
            mem_req_d = 1'b0;
            state_d   = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Buffer entries: next-state
   // ---------------------------------------------------------------------
   always_comb begin
      valid0_d = valid0_q;
      tag0_d   = tag0_q;
      data0_d  = data0_q;
`ifdef IFETCH_PREFETCH_EN
      valid1_d = valid1_q;
      tag1_d   = tag1_q;
      data1_d  = data1_q;

      if (promote) begin
         valid0_d = 1'b1;
         tag0_d   = tag1_q;
         data0_d  = data1_q;
         valid1_d = 1'b0;
      end
`endif

      // A demand fill wins over a promotion in the same cycle
      if (fill0) begin
         valid0_d = 1'b1;
         tag0_d   = mem_tag_q;
         data0_d  = MEM_RDATA;
`ifdef IFETCH_PREFETCH_EN
         valid1_d = 1'b0;
`endif
      end

`ifdef IFETCH_PREFETCH_EN
      if (fill1) begin
         valid1_d = 1'b1;
         tag1_d   = mem_tag_q;
         data1_d  = MEM_RDATA;
      end
`endif

      if (FLUSH) begin
         valid0_d = 1'b0;
`ifdef IFETCH_PREFETCH_EN
         valid1_d = 1'b0;
`endif
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= StIdle;
         mem_req_q <= 1'b0;
         mem_tag_q <= 30'd0;
      end else begin
         state_q   <= state_d;
         mem_req_q <= mem_req_d;
         mem_tag_q <= mem_tag_d;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid0_q <= 1'b0;
         tag0_q   <= 30'd0;
         data0_q  <= 32'h0000_0000;
      end else begin
         valid0_q <= valid0_d;
         tag0_q   <= tag0_d;
         data0_q  <= data0_d;
      end
   end

`ifdef IFETCH_PREFETCH_EN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid1_q <= 1'b0;
         tag1_q   <= 30'd0;
         data1_q  <= 32'h0000_0000;
      end else begin
         valid1_q <= valid1_d;
         tag1_q   <= tag1_d;
         data1_q  <= data1_d;
      end
   end
`endif

endmodule

// File: tb/tb_thumb_ifetch_port.sv
// Directed testbench for thumb_ifetch_port. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge. A small memory
// responder acknowledges requests after a programmable number of wait states.

module tb_thumb_ifetch_port;

   logic        CLK;
   logic        nRST;
   logic        FETCH_REQ;
   logic [31:0] FETCH_ADDR;
   logic        FLUSH;
   logic        FETCH_RDY;
   logic [15:0] INST;
   logic        MEM_REQ;
   logic [31:0] MEM_ADDR;
   logic        MEM_ACK;
   logic [31:0] MEM_RDATA;

   int checks = 0;
   int errors = 0;
   int mem_wait = 0;
   int wcnt = 0;

   thumb_ifetch_port dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .FETCH_REQ  (FETCH_REQ),
      .FETCH_ADDR (FETCH_ADDR),
      .FLUSH      (FLUSH),
      .FETCH_RDY  (FETCH_RDY),
      .INST       (INST),
      .MEM_REQ    (MEM_REQ),
      .MEM_ADDR   (MEM_ADDR),
      .MEM_ACK    (MEM_ACK),
      .MEM_RDATA  (MEM_RDATA)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0100: mem_word = 32'hBEEF_1234;
         32'h0000_0200: mem_word = 32'hCAFE_5678;
         32'h0000_0300: mem_word = 32'h0BAD_F00D;
         32'hFFFF_FFF8: mem_word = 32'h1111_2222;
         32'hFFFF_FFFC: mem_word = 32'h3333_4444;
         32'h0000_0000: mem_word = 32'h5555_6666;
         default:       mem_word = 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   // Memory responder: ACK after mem_wait cycles of MEM_REQ
   initial begin
      MEM_ACK   = 1'b0;
      MEM_RDATA = 32'h0;
      forever begin
         @(posedge CLK);
         #1;
         if (nRST && MEM_REQ) begin
            if (wcnt == mem_wait) begin
               MEM_ACK   = 1'b1;
               MEM_RDATA = mem_word(MEM_ADDR);
               wcnt      = 0;
            end else begin
               MEM_ACK   = 1'b0;
               MEM_RDATA = 32'h0;
               wcnt++;
            end
         end else begin
            MEM_ACK   = 1'b0;
            MEM_RDATA = 32'h0;
            wcnt      = 0;
         end
      end
   end

   initial begin
      nRST       = 1'b0;
      FETCH_REQ  = 1'b0;
      FETCH_ADDR = 32'h0;
      FLUSH      = 1'b0;

      repeat (2) @(negedge CLK);
      check("rst_rdy", {31'd0, FETCH_RDY}, 32'd0);
      check("rst_inst", {16'd0, INST}, 32'd0);
      check("rst_req", {31'd0, MEM_REQ}, 32'd0);
      check("rst_addr", MEM_ADDR, 32'h0);
      next_cycle();
      nRST = 1'b1;

`ifdef IFETCH_PREFETCH_EN
      // Sequential fetch across the address wrap with prefetch
      mem_wait   = 0;
      FETCH_REQ  = 1'b1;
      FETCH_ADDR = 32'hFFFF_FFF8;
      @(negedge CLK);
      check("pf_c0_rdy", {31'd0, FETCH_RDY}, 32'd0);
      next_cycle();
      @(negedge CLK);
      check("pf_c1_req", {31'd0, MEM_REQ}, 32'd1);
      check("pf_c1_addr", MEM_ADDR, 32'hFFFF_FFF8);
      next_cycle();
      @(negedge CLK);
      check("pf_c2_rdy", {31'd0, FETCH_RDY}, 32'd1);
      check("pf_c2_inst", {16'd0, INST}, 32'h2222);
      check("pf_c2_req", {31'd0, MEM_REQ}, 32'd0);
      next_cycle();
      FETCH_ADDR = 32'hFFFF_FFFA;
      @(negedge CLK);
      check("pf_c3_inst", {16'd0, INST}, 32'h1111);
      check("pf_c3_req", {31'd0, MEM_REQ}, 32'd1);
      check("pf_c3_addr", MEM_ADDR, 32'hFFFF_FFFC);
      next_cycle();
      FETCH_ADDR = 32'hFFFF_FFFC;
      @(negedge CLK);
      check("pf_c4_rdy", {31'd0, FETCH_RDY}, 32'd1);
      check("pf_c4_inst", {16'd0, INST}, 32'h4444);
      check("pf_c4_req", {31'd0, MEM_REQ}, 32'd0);
      next_cycle();
      FETCH_ADDR = 32'hFFFF_FFFE;
      @(negedge CLK);
      check("pf_c5_inst", {16'd0, INST}, 32'h3333);
      check("pf_c5_req", {31'd0, MEM_REQ}, 32'd1);
      check("pf_c5_addr", MEM_ADDR, 32'h0000_0000);
      next_cycle();
      FETCH_ADDR = 32'h0000_0000;
      @(negedge CLK);
      check("pf_c6_rdy", {31'd0, FETCH_RDY}, 32'd1);
      check("pf_c6_inst", {16'd0, INST}, 32'h6666);
`else
      // Miss with zero-wait memory, then sequential hit
      mem_wait   = 0;
      FETCH_REQ  = 1'b1;
      FETCH_ADDR = 32'h0000_0100;
      @(negedge CLK);
      check("m0_rdy", {31'd0, FETCH_RDY}, 32'd0);
      check("m0_req", {31'd0, MEM_REQ}, 32'd0);
      next_cycle();
      @(negedge CLK);
      check("m1_req", {31'd0, MEM_REQ}, 32'd1);
      check("m1_addr", MEM_ADDR, 32'h100);
      check("m1_rdy", {31'd0, FETCH_RDY}, 32'd0);
      next_cycle();
      @(negedge CLK);
      check("m2_rdy", {31'd0, FETCH_RDY}, 32'd1);
      check("m2_inst", {16'd0, INST}, 32'h1234);
      check("m2_req", {31'd0, MEM_REQ}, 32'd0);
      next_cycle();
      FETCH_ADDR = 32'h0000_0102;
      @(negedge CLK);
      check("seq_rdy", {31'd0, FETCH_RDY}, 32'd1);
      check("seq_inst", {16'd0, INST}, 32'hBEEF);
      check("seq_req", {31'd0, MEM_REQ}, 32'd0);

      // Three wait states
      next_cycle();
      mem_wait   = 3;
      FETCH_ADDR = 32'h0000_0200;
      @(negedge CLK);
      check("ws0_rdy", {31'd0, FETCH_RDY}, 32'd0);
      for (int i = 1; i <= 4; i++) begin
         next_cycle();
         @(negedge CLK);
         check("ws_req", {31'd0, MEM_REQ}, 32'd1);
         check("ws_addr", MEM_ADDR, 32'h200);
         check("ws_rdy", {31'd0, FETCH_RDY}, 32'd0);
         check("ws_inst", {16'd0, INST}, 32'd0);
      end
      next_cycle();
      @(negedge CLK);
      check("ws_done_rdy", {31'd0, FETCH_RDY}, 32'd1);
      check("ws_done_inst", {16'd0, INST}, 32'h5678);
      next_cycle();
      FETCH_ADDR = 32'h0000_0202;
      @(negedge CLK);
      check("ws_hi_inst", {16'd0, INST}, 32'hCAFE);

      // FLUSH in WAIT before ACK
      next_cycle();
      FETCH_ADDR = 32'h0000_0300;
      @(negedge CLK);
      check("fw0_rdy", {31'd0, FETCH_RDY}, 32'd0);
      next_cycle();
      FLUSH = 1'b1;
      @(negedge CLK);
      check("fw1_req", {31'd0, MEM_REQ}, 32'd1);
      check("fw1_addr", MEM_ADDR, 32'h300);
      check("fw1_rdy", {31'd0, FETCH_RDY}, 32'd0);
      next_cycle();
      FLUSH      = 1'b0;
      FETCH_ADDR = 32'h0000_0200;
      @(negedge CLK);
      check("fw2_rdy", {31'd0, FETCH_RDY}, 32'd0);
      check("fw2_addr", MEM_ADDR, 32'h300);
      next_cycle();
      @(negedge CLK);
      check("fw3_req", {31'd0, MEM_REQ}, 32'd1);
      next_cycle();
      @(negedge CLK);
      check("fw4_req", {31'd0, MEM_REQ}, 32'd1);
      next_cycle();
      mem_wait = 0;
      @(negedge CLK);
      check("fw5_req", {31'd0, MEM_REQ}, 32'd0);
      check("fw5_rdy", {31'd0, FETCH_RDY}, 32'd0);
      next_cycle();
      @(negedge CLK);
      check("fw6_req", {31'd0, MEM_REQ}, 32'd1);
      check("fw6_addr", MEM_ADDR, 32'h200);
      next_cycle();
      @(negedge CLK);
      check("fw7_rdy", {31'd0, FETCH_RDY}, 32'd1);
      check("fw7_inst", {16'd0, INST}, 32'h5678);
      next_cycle();
      FETCH_ADDR = 32'h0000_0300;
      @(negedge CLK);
      check("stale_rdy", {31'd0, FETCH_RDY}, 32'd0);
      next_cycle();
      @(negedge CLK);
      check("stale_addr", MEM_ADDR, 32'h300);
      next_cycle();
      @(negedge CLK);
      check("f300_inst", {16'd0, INST}, 32'hF00D);

      // FLUSH coincident with a hit
      next_cycle();
      FLUSH = 1'b1;
      @(negedge CLK);
      check("fh_rdy", {31'd0, FETCH_RDY}, 32'd0);
      check("fh_inst", {16'd0, INST}, 32'd0);
      next_cycle();
      FLUSH = 1'b0;
      @(negedge CLK);
      check("fh_miss_rdy", {31'd0, FETCH_RDY}, 32'd0);
      check("fh_miss_req", {31'd0, MEM_REQ}, 32'd0);
      next_cycle();
      @(negedge CLK);
      check("fh_refetch_req", {31'd0, MEM_REQ}, 32'd1);
      check("fh_refetch_addr", MEM_ADDR, 32'h300);
      next_cycle();
      @(negedge CLK);
      check("fh_refill_inst", {16'd0, INST}, 32'hF00D);

      // FLUSH coincident with ACK in WAIT
      next_cycle();
      mem_wait   = 1;
      FETCH_ADDR = 32'h0000_0100;
      @(negedge CLK);
      check("fa0_rdy", {31'd0, FETCH_RDY}, 32'd0);
      next_cycle();
      @(negedge CLK);
      check("fa1_req", {31'd0, MEM_REQ}, 32'd1);
      next_cycle();
      FLUSH = 1'b1;
      @(negedge CLK);
      check("fa2_req", {31'd0, MEM_REQ}, 32'd1);
      next_cycle();
      FLUSH = 1'b0;
      @(negedge CLK);
      check("fa3_req", {31'd0, MEM_REQ}, 32'd0);
      check("fa3_rdy", {31'd0, FETCH_RDY}, 32'd0);
      next_cycle();
      @(negedge CLK);
      check("fa4_req", {31'd0, MEM_REQ}, 32'd1);
      check("fa4_addr", MEM_ADDR, 32'h100);
      next_cycle();
      next_cycle();
      @(negedge CLK);
      check("fa6_rdy", {31'd0, FETCH_RDY}, 32'd1);
      check("fa6_inst", {16'd0, INST}, 32'h1234);

      // No request: outputs idle
      next_cycle();
      FETCH_REQ = 1'b0;
      @(negedge CLK);
      check("noreq_rdy", {31'd0, FETCH_RDY}, 32'd0);
      check("noreq_inst", {16'd0, INST}, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
